// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a variable-latency req/ack memory port.
// Handles lane steering, byte enables, load extension, misalignment faults and bus timeouts.
module load_store_unit #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic                op_load,
    input  logic [1:0]          op_size,
    input  logic                op_signed,
    input  logic [ADDR_W-1:0]   op_addr,
    input  logic [DATA_W-1:0]   op_wdata,
    input  logic [4:0]          op_rd,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic [4:0]          resp_rd,
    output logic                misalign,
    output logic                bus_err
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [1:0]          size_reg;
    logic                load_reg;
    logic                signed_reg;
    logic [OFF_W-1:0]    shift_reg;
    logic [4:0]          rd_reg;

    logic                op_ready_reg;
    logic                mem_req_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [NB-1:0]       mem_be_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic                resp_valid_reg;
    logic [DATA_W-1:0]   resp_data_reg;
    logic [4:0]          resp_rd_reg;
    logic                misalign_reg;
    logic                bus_err_reg;

    logic                misaligned_c;
    int                  nbytes_c;
    logic [OFF_W-1:0]    lane_shift_c;
    logic [NB-1:0]       be_c;
    logic [DATA_W-1:0]   wdata_c;
    logic [DATA_W-1:0]   shifted_c;
    logic [DATA_W-1:0]   mask_c;
    logic                sign_c;
    logic [DATA_W-1:0]   load_c;

    // lane_shift is the lowest lane touched by the access, in either byte order
    always_comb begin
        misaligned_c = 1'b0;
        wdata_c      = op_wdata;
        nbytes_c     = 1 << op_size;
        case (op_size)
            2'b00: wdata_c = {NB{op_wdata[7:0]}};
            2'b01: begin
                misaligned_c = op_addr[0];
                wdata_c      = {(NB/2){op_wdata[15:0]}};
            end
            2'b10: begin
                misaligned_c = |op_addr[1:0];
                wdata_c      = {(NB/4){op_wdata[31:0]}};
            end
            default: misaligned_c = (DATA_W == 32) || (|op_addr[2:0]);
        endcase
        lane_shift_c = (BIG_ENDIAN != 0) ? OFF_W'(NB - int'(op_addr[OFF_W-1:0]) - nbytes_c)
                                         : op_addr[OFF_W-1:0];
        be_c = NB'(((1 << nbytes_c) - 1) << lane_shift_c);
    end

    always_comb begin
        shifted_c = mem_rdata >> {shift_reg, 3'b000};
        case (size_reg)
            2'b00:   begin mask_c = DATA_W'(8'hFF);         sign_c = shifted_c[7];        end
            2'b01:   begin mask_c = DATA_W'(16'hFFFF);      sign_c = shifted_c[15];       end
            2'b10:   begin mask_c = DATA_W'(32'hFFFF_FFFF); sign_c = shifted_c[31];       end
            default: begin mask_c = '1;                     sign_c = shifted_c[DATA_W-1]; end
        endcase
        load_c = (signed_reg && sign_c) ? (shifted_c | ~mask_c) : (shifted_c & mask_c);
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            size_reg       <= '0;
            load_reg       <= 1'b0;
            signed_reg     <= 1'b0;
            shift_reg      <= '0;
            rd_reg         <= '0;
            op_ready_reg   <= 1'b1;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_be_reg     <= '0;
            mem_wdata_reg  <= '0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_rd_reg    <= '0;
            misalign_reg   <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            misalign_reg   <= 1'b0;
            bus_err_reg    <= 1'b0;
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (op_valid) begin
                        if (misaligned_c) begin
                            misalign_reg <= 1'b1;
                        end else begin
                            state_reg     <= REQ;
                            op_ready_reg  <= 1'b0;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= ~op_load;
                            mem_addr_reg  <= {op_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_be_reg    <= be_c;
                            mem_wdata_reg <= wdata_c;
                            size_reg      <= op_size;
                            load_reg      <= op_load;
                            signed_reg    <= op_signed;
                            shift_reg     <= lane_shift_c;
                            rd_reg        <= op_rd;
                            cnt_reg       <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        cnt_reg     <= '0;
                        if (load_reg) begin
                            resp_data_reg  <= load_c;
                            resp_rd_reg    <= rd_reg;
                            resp_valid_reg <= 1'b1;
                            state_reg      <= RESP;
                        end else begin
                            state_reg    <= IDLE;
                            op_ready_reg <= 1'b1;
                        end
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        // this is the TIMEOUT-th cycle without an ack
                        bus_err_reg  <= 1'b1;
                        mem_req_reg  <= 1'b0;
                        mem_we_reg   <= 1'b0;
                        cnt_reg      <= '0;
                        state_reg    <= IDLE;
                        op_ready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    state_reg    <= IDLE;
                    op_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= IDLE;
                    op_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign op_ready   = op_ready_reg;
    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_be     = mem_be_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_rd    = resp_rd_reg;
    assign misalign   = misalign_reg;
    assign bus_err    = bus_err_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a 32-bit big-endian and a 64-bit little-endian
// instance, each with its own driver, memory responder and output monitor.
module tb_load_store_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    localparam int K_MIS  = 0;
    localparam int K_BERR = 1;
    localparam int K_RESP = 2;

    typedef struct {
        int          kind;
        logic [63:0] data;
        logic [4:0]  rd;
        int          cyc;
    } ev_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          delay;
    } rq_t;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-by-byte view of the memory word
    function automatic int lane_of(int nb, int bige, int off);
        return (bige != 0) ? nb - 1 - off : off;
    endfunction

    function automatic logic [7:0] m_be(int nb, int bige, logic [31:0] a, int n);
        logic [7:0] r;
        int o;
        r = '0;
        o = int'(a % nb);
        for (int k = 0; k < n; k++) r[lane_of(nb, bige, o + k)] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] m_wdata(int nb, logic [63:0] wd, int n);
        logic [63:0] r;
        r = '0;
        for (int l = 0; l < nb; l++) r[8*l +: 8] = wd[8*(l % n) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_load(int nb, int bige, logic [31:0] a, int n,
                                           logic sg, logic [63:0] rdv);
        logic [63:0] v;
        logic [63:0] mask;
        int o;
        int pos;
        v = '0;
        o = int'(a % nb);
        for (int j = 0; j < n; j++) begin
            pos = (bige != 0) ? n - 1 - j : j;
            v[8*pos +: 8] = rdv[8*lane_of(nb, bige, o + j) +: 8];
        end
        if (n < 8) begin
            mask = (64'd1 << (8 * n)) - 64'd1;
            if (sg && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int DW   = (gi == 0) ? 32 : 64;
        localparam int NB   = DW / 8;
        localparam int BIGE = (gi == 0) ? 1 : 0;
        localparam int TO   = (gi == 0) ? 8 : 4;

        logic          rst_n;
        logic          op_valid;
        logic          op_ready;
        logic          op_load;
        logic [1:0]    op_size;
        logic          op_signed;
        logic [31:0]   op_addr;
        logic [DW-1:0] op_wdata;
        logic [4:0]    op_rd;
        logic          mem_req;
        logic          mem_we;
        logic [31:0]   mem_addr;
        logic [NB-1:0] mem_be;
        logic [DW-1:0] mem_wdata;
        logic          mem_ack;
        logic [DW-1:0] mem_rdata;
        logic          resp_valid;
        logic [DW-1:0] resp_data;
        logic [4:0]    resp_rd;
        logic          misalign;
        logic          bus_err;

        ev_t evq[$];
        rq_t rqq[$];
        bit  done = 1'b0;

        load_store_unit #(.DATA_W(DW), .ADDR_W(32), .BIG_ENDIAN(BIGE), .TIMEOUT(TO)) dut (
            .CLK(clk), .reset_n(rst_n),
            .op_valid(op_valid), .op_ready(op_ready), .op_load(op_load),
            .op_size(op_size), .op_signed(op_signed), .op_addr(op_addr),
            .op_wdata(op_wdata), .op_rd(op_rd),
            .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
            .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
            .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
            .misalign(misalign), .bus_err(bus_err)
        );

        function automatic string nm(string s);
            return $sformatf("d%0d_%s", gi, s);
        endfunction

        // Drive one request at a negedge and record what the unit must do with it
        task automatic issue(logic ld, logic [1:0] sz, logic sg, logic [31:0] addr,
                             logic [63:0] wd, logic [63:0] rdv, int delay, bit abandon);
            int n;
            int w;
            ev_t e;
            rq_t r;
            logic [63:0] dmask;
            n = 1 << sz;
            w = 0;
            dmask = (DW == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
            while (!op_ready && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (!op_ready) chk(nm("ready_wait"), 64'(op_ready), 64'd1);
            op_valid  = 1'b1;
            op_load   = ld;
            op_size   = sz;
            op_signed = sg;
            op_addr   = addr;
            op_wdata  = wd[DW-1:0];
            op_rd     = 5'($urandom);
            $display("dut%0d cyc=%0d %s size=%0d signed=%0d addr=%h wdata=%h rdata=%h delay=%0d",
                     gi, cyc, ld ? "load " : "store", n, sg, addr, wd, rdv, delay);
            if (n > NB || (addr % n) != 0) begin
                e.kind = K_MIS; e.data = '0; e.rd = '0; e.cyc = cyc + 1;
                evq.push_back(e);
            end else begin
                r.we    = ~ld;
                r.addr  = addr & ~32'(NB - 1);
                r.be    = m_be(NB, BIGE, addr, n);
                r.wdata = m_wdata(NB, wd, n);
                r.rdata = rdv;
                r.delay = delay;
                rqq.push_back(r);
                if (!abandon) begin
                    if (delay >= TO) begin
                        e.kind = K_BERR; e.data = '0; e.rd = '0; e.cyc = cyc + 1 + TO;
                        evq.push_back(e);
                    end else if (ld) begin
                        e.kind = K_RESP;
                        e.data = m_load(NB, BIGE, addr, n, sg, rdv) & dmask;
                        e.rd   = op_rd;
                        e.cyc  = cyc + 2 + delay;
                        evq.push_back(e);
                    end
                end
            end
            @(negedge clk);
            op_valid = 1'b0;
        endtask

        // Memory responder: checks every REQ cycle, acks after the recorded delay
        initial begin
            int  cnt;
            bit  active;
            rq_t r;
            cnt = 0;
            active = 1'b0;
            r = '{we: 1'b0, addr: '0, be: '0, wdata: '0, rdata: '0, delay: 0};
            mem_ack = 1'b0;
            mem_rdata = '0;
            forever begin
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = DW'({$urandom, $urandom});
                if (!mem_req) begin
                    active  = 1'b0;
                    mem_ack = 1'($urandom_range(0, 1));
                end else begin
                    if (!active) begin
                        if (rqq.size() == 0) begin
                            chk(nm("unexpected_req"), 64'd1, 64'd0);
                            r.delay = 0;
                        end else begin
                            r = rqq.pop_front();
                        end
                        active = 1'b1;
                        cnt = 0;
                    end
                    chk(nm("mem_we"),    64'(mem_we),    64'(r.we));
                    chk(nm("mem_addr"),  64'(mem_addr),  64'(r.addr));
                    chk(nm("mem_be"),    64'(mem_be),    64'(r.be));
                    chk(nm("mem_wdata"), 64'(mem_wdata), r.wdata);
                    chk(nm("ready_in_req"), 64'(op_ready), 64'd0);
                    if (cnt == r.delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = r.rdata[DW-1:0];
                        active    = 1'b0;
                    end
                    cnt++;
                end
            end
        end

        // Output monitor: every pulse pops the scoreboard and is checked against it
        initial begin
            logic [2:0] fl;
            ev_t e;
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    fl = {resp_valid, bus_err, misalign};
                    for (int k = 0; k < 3; k++) begin
                        if (fl[k]) begin
                            if (evq.size() == 0) begin
                                chk(nm($sformatf("unexpected_event%0d", k)), 64'd1, 64'd0);
                            end else begin
                                e = evq.pop_front();
                                chk(nm("event_kind"), 64'(k), 64'(e.kind));
                                chk(nm("event_cycle"), 64'(cyc), 64'(e.cyc));
                                if (k == K_RESP) begin
                                    chk(nm("resp_data"), 64'(resp_data), e.data);
                                    chk(nm("resp_rd"), 64'(resp_rd), 64'(e.rd));
                                    chk(nm("ready_in_resp"), 64'(op_ready), 64'd0);
                                end
                                if (k == K_MIS) chk(nm("ready_on_misalign"), 64'(op_ready), 64'd1);
                            end
                        end
                    end
                end
            end
        end

        // Driver
        initial begin
            logic        ld;
            logic        sg;
            logic [1:0]  sz;
            logic [31:0] addr;
            int          n;
            int          delay;
            rst_n = 1'b0;
            op_valid = 1'b0; op_load = 1'b0; op_size = '0; op_signed = 1'b0;
            op_addr = '0; op_wdata = '0; op_rd = '0;
            repeat (3) @(negedge clk);
            chk(nm("rst_op_ready"),   64'(op_ready),   64'd1);
            chk(nm("rst_mem_req"),    64'(mem_req),    64'd0);
            chk(nm("rst_mem_we"),     64'(mem_we),     64'd0);
            chk(nm("rst_mem_be"),     64'(mem_be),     64'd0);
            chk(nm("rst_mem_addr"),   64'(mem_addr),   64'd0);
            chk(nm("rst_resp_valid"), 64'(resp_valid), 64'd0);
            chk(nm("rst_resp_data"),  64'(resp_data),  64'd0);
            chk(nm("rst_misalign"),   64'(misalign),   64'd0);
            chk(nm("rst_bus_err"),    64'(bus_err),    64'd0);
            rst_n = 1'b1;
            @(negedge clk);

            if (gi == 0) begin
                issue(1'b1, 2'b00, 1'b1, 32'h101, 64'd0, 64'h1280_3456, 0, 1'b0);
                issue(1'b1, 2'b01, 1'b0, 32'h102, 64'd0, 64'hAAAA_8001, 0, 1'b0);
                issue(1'b1, 2'b01, 1'b1, 32'h102, 64'd0, 64'hAAAA_8001, 0, 1'b0);
                issue(1'b0, 2'b01, 1'b0, 32'h206, 64'h1234_BEEF, 64'd0, 5, 1'b0);
                issue(1'b1, 2'b10, 1'b0, 32'h003, 64'd0, 64'd0, 0, 1'b0);
                issue(1'b0, 2'b10, 1'b0, 32'h004, 64'hCAFE_F00D, 64'd0, 1, 1'b0);
                issue(1'b1, 2'b11, 1'b0, 32'h008, 64'd0, 64'd0, 0, 1'b0);
            end else begin
                issue(1'b1, 2'b11, 1'b0, 32'h008, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
                issue(1'b0, 2'b10, 1'b0, 32'h010, 64'h5555_AAAA, 64'd0, TO + 5, 1'b0);
                issue(1'b1, 2'b10, 1'b0, 32'h014, 64'd0, 64'hFEDC_BA98_7654_3210, TO - 1, 1'b0);
                issue(1'b1, 2'b10, 1'b1, 32'h014, 64'd0, 64'hFEDC_BA98_7654_3210, 0, 1'b0);
                issue(1'b1, 2'b01, 1'b1, 32'h019, 64'd0, 64'd0, 0, 1'b0);
            end

            for (int i = 0; i < 60; i++) begin
                ld   = 1'($urandom_range(0, 1));
                sg   = 1'($urandom_range(0, 1));
                sz   = 2'($urandom_range(0, 3));
                n    = 1 << sz;
                addr = $urandom;
                if ($urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
                delay = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 2))
                                                    : int'($urandom_range(0, TO - 1));
                issue(ld, sz, sg, addr, {$urandom, $urandom}, {$urandom, $urandom}, delay, 1'b0);
            end

            // Reset in the middle of a request abandons it without any response
            issue(1'b1, 2'b10, 1'b0, 32'h40, 64'd0, 64'h1111_2222_3333_4444, 1000, 1'b1);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk(nm("async_rst_mem_req"),  64'(mem_req),    64'd0);
            chk(nm("async_rst_op_ready"), 64'(op_ready),   64'd1);
            chk(nm("async_rst_resp"),     64'(resp_valid), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            issue(1'b1, 2'b00, 1'b0, 32'h4B, 64'd0, {$urandom, $urandom}, 1, 1'b0);

            repeat (TO + 10) @(negedge clk);
            chk(nm("events_left"),   64'(evq.size()), 64'd0);
            chk(nm("requests_left"), 64'(rqq.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 40000; t++) begin
            if (g_dut[0].done && g_dut[1].done) break;
            @(posedge clk);
        end
        chk("completion", {62'd0, g_dut[1].done, g_dut[0].done}, 64'd3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
